pipe_stage_skid: RTL and testbench

Parametrised pipeline-stage register with a valid/ready handshake, a one-entry skid buffer, synchronous flush, and masking of side-effect enables. It replaces the fixed-field freeze/clear inter-stage flops between any two pipeline stages (F/D, D/E, E/M, M/W). Upstream stalls are decoupled through a registered `in_ready`. A saturating stall counter gives performance visibility.

---
 rtl/pipe_pkg.sv | 13 +
 rtl/sat_counter.sv | 38 +++
 rtl/pipe_stage_skid.sv | 111 +++++++++++
 tb/tb_pipe_stage_skid.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for pipeline stage registers
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } pipe_state_t;

    // Counters slice their saturation value out of this, so CNT_W is limited to 64.
    localparam logic [63:0] SAT_ALL_ONES = '1;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with clear priority over increment
module sat_counter
    import pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             global_rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] SAT_VAL = SAT_ALL_ONES[CNT_W-1:0];

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != SAT_VAL)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - stage register with one-entry skid, flush and side-effect masking
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int SE_W   = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              global_rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [SE_W-1:0]   in_se,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [SE_W-1:0]   out_se,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              cnt_clr
);

    pipe_state_t       state_q, state_d;
    logic              in_ready_q;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [SE_W-1:0]   main_se_q, main_se_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [SE_W-1:0]   skid_se_q, skid_se_d;
    logic              in_xfer;
    logic              out_xfer;

    assign out_valid = (state_q != EMPTY);
    assign in_xfer   = in_valid && in_ready_q;
    assign out_xfer  = out_valid && out_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_se_d   = main_se_q;
        skid_data_d = skid_data_q;
        skid_se_d   = skid_se_q;
        // Flush only clears occupancy; payload registers keep their contents.
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        state_d     = FULL;
                        main_data_d = in_data;
                        main_se_d   = in_se;
                    end
                end
                FULL: begin
                    if (in_xfer && out_xfer) begin
                        main_data_d = in_data;
                        main_se_d   = in_se;
                    end else if (in_xfer) begin
                        state_d     = SKID;
                        skid_data_d = in_data;
                        skid_se_d   = in_se;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end
                end
                SKID: begin
                    if (out_xfer) begin
                        state_d     = FULL;
                        main_data_d = skid_data_q;
                        main_se_d   = skid_se_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            main_data_q <= '0;
            main_se_q   <= '0;
            skid_data_q <= '0;
            skid_se_q   <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != SKID);
            main_data_q <= main_data_d;
            main_se_q   <= main_se_d;
            skid_data_q <= skid_data_d;
            skid_se_q   <= skid_se_d;
        end
    end

    assign in_ready = in_ready_q;
    assign out_data = main_data_q;
    assign out_se   = main_se_q & {SE_W{out_valid}};

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk         (clk),
        .global_rst_n(global_rst_n),
        .inc         (out_valid && !out_ready),
        .clr         (cnt_clr),
        .count       (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - self-checking bench for pipe_stage_skid
module tb_pipe_stage_skid;

    localparam int DW = 16;
    localparam int SW = 2;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          global_rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [SW-1:0] in_se = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [SW-1:0] out_se;
    logic [CW-1:0] stall_cnt;
    logic          cnt_clr = 1'b0;

    int total = 0;
    int bad = 0;

    pipe_stage_skid #(.DATA_W(DW), .SE_W(SW), .CNT_W(CW)) dut (
        .clk         (clk),
        .global_rst_n(global_rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_se       (in_se),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_se      (out_se),
        .stall_cnt   (stall_cnt),
        .cnt_clr     (cnt_clr)
    );

    always #5 clk = ~clk;

    // Model: the stage is a FIFO of capacity two whose head is visible.
    logic [SW+DW-1:0] mq[$];
    logic             m_ready = 1'b1;
    int               m_cnt = 0;
    logic [DW-1:0]    dut_log[$];

    always @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            mq.delete();
            m_ready = 1'b1;
            m_cnt   = 0;
        end else begin
            automatic bit pop   = (mq.size() > 0) && out_ready;
            automatic bit push  = in_valid && m_ready;
            automatic bit stall = (mq.size() > 0) && !out_ready;
            if (cnt_clr) m_cnt = 0;
            else if (stall && m_cnt < 15) m_cnt = m_cnt + 1;
            if (flush) begin
                mq.delete();
            end else begin
                if (pop) mq.delete(0);
                if (push) mq.push_back({in_se, in_data});
            end
            m_ready = (mq.size() < 2);
        end
    end

    always @(posedge clk) begin
        if (global_rst_n && out_valid && out_ready) dut_log.push_back(out_data);
    end

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        automatic bit mv = (mq.size() > 0);
        check("out_valid", out_valid, mv);
        check("in_ready", in_ready, m_ready);
        check("stall_cnt", stall_cnt, m_cnt);
        if (mv) begin
            check("out_data", out_data, mq[0][DW-1:0]);
            check("out_se", out_se, mq[0][SW+DW-1:DW]);
        end else begin
            check("out_se_idle", out_se, 0);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_log(input string name, input logic [DW-1:0] exp[$]);
        check({name, "_len"}, dut_log.size(), exp.size());
        for (int i = 0; i < exp.size() && i < dut_log.size(); i++)
            check(name, dut_log[i], exp[i]);
    endtask

    task automatic send(input logic [DW-1:0] d, input logic [SW-1:0] se);
        in_valid = 1'b1;
        in_data  = d;
        in_se    = se;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        automatic logic [DW-1:0] exp[$];

        step(3);
        check("rst_out_data", out_data, 0);
        check("rst_in_ready", in_ready, 1);
        global_rst_n = 1'b1;
        step();

        // Streaming 1..8 with downstream always ready.
        out_ready = 1'b1;
        dut_log.delete();
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(i);
            in_se    = 2'b01;
            step();
            check("stream_ready", in_ready, 1);
            check("stream_head", out_data, i);
        end
        in_valid = 1'b0;
        step(2);
        exp = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
        check_log("stream_order", exp);

        // Backpressure into skid, then drain in order.
        out_ready = 1'b0;
        dut_log.delete();
        send(16'hA0A0, 2'b00);
        send(16'hB0B0, 2'b00);
        check("skid_ready", in_ready, 0);
        check("skid_head", out_data, 16'hA0A0);
        step(2);
        out_ready = 1'b1;
        step(3);
        exp = {16'hA0A0, 16'hB0B0};
        check_log("bp_order", exp);
        check("bp_ready_back", in_ready, 1);

        // Flush while in SKID with C offered.
        out_ready = 1'b0;
        dut_log.delete();
        send(16'h0D01, 2'b10);
        send(16'h0D02, 2'b10);
        in_valid = 1'b1;
        in_data  = 16'h0C0C;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", out_valid, 0);
        check("flush_ready", in_ready, 1);
        out_ready = 1'b1;
        step(3);
        check("flush_no_c", dut_log.size(), 0);

        // Flush together with an accepted beat from EMPTY drops the beat.
        in_valid = 1'b1;
        in_data  = 16'h0E0E;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_drop_valid", out_valid, 0);
        step();

        // Side-effect masking.
        out_ready = 1'b0;
        send(16'h5555, 2'b11);
        check("se_held", out_se, 2'b11);
        out_ready = 1'b1;
        step();
        check("se_masked", out_se, 2'b00);
        check("se_drained", out_valid, 0);

        // Stall counter saturation and clear priority.
        cnt_clr = 1'b1;
        step();
        cnt_clr   = 1'b0;
        out_ready = 1'b0;
        send(16'h7777, 2'b00);
        step(20);
        check("cnt_sat", stall_cnt, 15);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        check("cnt_clr_wins", stall_cnt, 0);
        step();
        check("cnt_restart", stall_cnt, 1);

        // Asynchronous reset with SKID occupied.
        send(16'h8888, 2'b11);
        check("pre_rst_skid", in_ready, 0);
        #2;
        global_rst_n = 1'b0;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_ready", in_ready, 1);
        check("rst_se", out_se, 0);
        check("rst_cnt", stall_cnt, 0);
        step(2);
        global_rst_n = 1'b1;
        out_ready = 1'b1;
        dut_log.delete();
        send(16'h0909, 2'b00);
        step(2);
        exp = {16'h0909};
        check_log("post_rst", exp);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
